// File: rtl/fma16_sched.sv
// fma16_sched: shares one fixed-latency fma16 datapath between two
// requesters with round-robin issue, owner tags and credited response FIFOs.
module fma16_sched #(
   parameter int LAT   = 3,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_x,
   input  logic [15:0] req0_y,
   input  logic [15:0] req0_z,
   input  logic [5:0]  req0_ctl,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_x,
   input  logic [15:0] req1_y,
   input  logic [15:0] req1_z,
   input  logic [5:0]  req1_ctl,
   output logic        dp_issue,
   output logic [15:0] dp_x,
   output logic [15:0] dp_y,
   output logic [15:0] dp_z,
   output logic [5:0]  dp_ctl,
   input  logic [15:0] dp_result,
   input  logic [3:0]  dp_flags,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [15:0] rsp0_result,
   output logic [3:0]  rsp0_flags,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp1_result,
   output logic [3:0]  rsp1_flags
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0]  credit [2];
   logic           ptr;
   logic [1:0]     elig;
   logic [1:0]     grant;
   logic [LAT-1:0] tag_v;
   logic [LAT-1:0] tag_o;
   logic [19:0]    mem [2][DEPTH];
   logic [AW:0]    wp [2];
   logic [AW:0]    rp [2];
   logic [1:0]     push;
   logic [1:0]     pop;
   logic [1:0]     empty;
   logic [1:0]     full;
   logic [19:0]    head0;
   logic [19:0]    head1;

   // Eligibility, round-robin grant and the operand mux into the datapath.
   always_comb begin
      elig[0] = req0_valid && (credit[0] < CW'(DEPTH));
      elig[1] = req1_valid && (credit[1] < CW'(DEPTH));
      grant[0] = elig[0] && (!elig[1] || !ptr);
      grant[1] = elig[1] && (!elig[0] || ptr);
      req0_ready = grant[0];
      req1_ready = grant[1];
      dp_issue = grant[0] || grant[1];
      dp_x = '0;
      dp_y = '0;
      dp_z = '0;
      dp_ctl = '0;
      if (grant[0]) begin
         dp_x = req0_x;
         dp_y = req0_y;
         dp_z = req0_z;
         dp_ctl = req0_ctl;
      end else if (grant[1]) begin
         dp_x = req1_x;
         dp_y = req1_y;
         dp_z = req1_z;
         dp_ctl = req1_ctl;
      end
   end

   // Pointer favours the requester that did not win last time.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= 1'b0;
      end else if (grant[0]) begin
         ptr <= 1'b1;
      end else if (grant[1]) begin
         ptr <= 1'b0;
      end
   end

   // Owner tags travel alongside the operation through the datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_v <= '0;
         tag_o <= '0;
      end else begin
         tag_v[0] <= dp_issue;
         tag_o[0] <= grant[1];
         for (int i = 1; i < LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_o[i] <= tag_o[i-1];
         end
      end
   end

   // FIFO status; result routed by the owner tag of the final stage.
   always_comb begin
      push[0] = tag_v[LAT-1] && !tag_o[LAT-1];
      push[1] = tag_v[LAT-1] && tag_o[LAT-1];
      for (int n = 0; n < 2; n++) begin
         empty[n] = (wp[n] == rp[n]);
         full[n] = (wp[n][AW] != rp[n][AW]) &&
                   (wp[n][AW-1:0] == rp[n][AW-1:0]);
      end
      rsp0_valid = !empty[0];
      rsp1_valid = !empty[1];
      pop[0] = rsp0_valid && rsp0_ready;
      pop[1] = rsp1_valid && rsp1_ready;
      head0 = empty[0] ? 20'h0 : mem[0][rp[0][AW-1:0]];
      head1 = empty[1] ? 20'h0 : mem[1][rp[1][AW-1:0]];
      rsp0_result = head0[15:0];
      rsp0_flags = head0[19:16];
      rsp1_result = head1[15:0];
      rsp1_flags = head1[19:16];
   end

   // Response storage; contents are don't-care until the pointer moves.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (push[n]) begin
            mem[n][wp[n][AW-1:0]] <= {dp_flags, dp_result};
         end
      end
   end

   // FIFO pointers.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (reset) begin
            wp[n] <= '0;
            rp[n] <= '0;
         end else begin
            if (push[n]) begin
               wp[n] <= wp[n] + (AW+1)'(1);
            end
            if (pop[n]) begin
               rp[n] <= rp[n] + (AW+1)'(1);
            end
         end
      end
   end

   // Credits cover in-flight plus buffered work, so a push never overflows.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (reset) begin
            credit[n] <= '0;
         end else begin
            credit[n] <= credit[n] + CW'(grant[n]) - CW'(pop[n]);
         end
      end
   end

   // A push into a full FIFO without a pop would lose a result.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (!reset) begin
            assert (!(push[n] && full[n] && !pop[n]))
               else $error("response fifo %0d overflow", n);
         end
      end
   end

endmodule

// File: tb/tb_fma16_sched.sv
// tb_fma16_sched: scoreboard bench for the shared fma16 scheduler,
// with a behavioural fixed-latency datapath.
module tb_fma16_sched;

   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0;
   logic        req0_ready;
   logic [15:0] req0_x = '0;
   logic [15:0] req0_y = '0;
   logic [15:0] req0_z = '0;
   logic [5:0]  req0_ctl = '0;
   logic        req1_valid = 1'b0;
   logic        req1_ready;
   logic [15:0] req1_x = '0;
   logic [15:0] req1_y = '0;
   logic [15:0] req1_z = '0;
   logic [5:0]  req1_ctl = '0;
   logic        dp_issue;
   logic [15:0] dp_x;
   logic [15:0] dp_y;
   logic [15:0] dp_z;
   logic [5:0]  dp_ctl;
   logic [15:0] dp_result;
   logic [3:0]  dp_flags;
   logic        rsp0_valid;
   logic        rsp0_ready = 1'b0;
   logic [15:0] rsp0_result;
   logic [3:0]  rsp0_flags;
   logic        rsp1_valid;
   logic        rsp1_ready = 1'b0;
   logic [15:0] rsp1_result;
   logic [3:0]  rsp1_flags;

   int vectors = 0;
   int miscompares = 0;
   int i0 = 0;
   int i1 = 0;
   logic [19:0] exp0 [$];
   logic [19:0] exp1 [$];
   logic [19:0] dpq [LAT];

   fma16_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
      .req0_ctl(req0_ctl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
      .req1_ctl(req1_ctl),
      .dp_issue(dp_issue), .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
      .dp_ctl(dp_ctl), .dp_result(dp_result), .dp_flags(dp_flags),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags)
   );

   always #5 clk = ~clk;

   function automatic real h2r(input logic [15:0] h);
      real r;
      int e;
      if (h[14:0] == 15'h0) return 0.0;
      r = 1.0 + real'(h[9:0]) / 1024.0;
      e = int'(h[14:10]) - 15;
      while (e > 0) begin r = r * 2.0; e--; end
      while (e < 0) begin r = r / 2.0; e++; end
      return h[15] ? -r : r;
   endfunction

   function automatic logic [15:0] r2h(input real v);
      logic s;
      int e;
      int mi;
      real a;
      if (v == 0.0) return 16'h0;
      s = (v < 0.0);
      a = s ? -v : v;
      e = 15;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0) begin a = a * 2.0; e--; end
      mi = int'((a - 1.0) * 1024.0);
      return {s, e[4:0], mi[9:0]};
   endfunction

   // Datapath behaviour: {flags, result} for exact small-integer operands.
   function automatic logic [19:0] model(input logic [15:0] x,
      input logic [15:0] y, input logic [15:0] z, input logic [5:0] c);
      real p;
      real q;
      p = c[5] ? h2r(x) * h2r(y) : h2r(x);
      if (c[3]) p = -p;
      q = c[4] ? h2r(z) : 0.0;
      if (c[2]) q = -q;
      return {x[0] ^ y[0], z[0], c[1:0], r2h(p + q)};
   endfunction

   // Fixed-latency datapath model.
   always @(posedge clk) begin
      dpq[0] <= model(dp_x, dp_y, dp_z, dp_ctl);
      for (int i = 1; i < LAT; i++) dpq[i] <= dpq[i-1];
   end
   assign dp_result = dpq[LAT-1][15:0];
   assign dp_flags = dpq[LAT-1][19:16];

   // Scoreboard: push at request handshake, pop and compare at response.
   always @(negedge clk) begin
      logic [19:0] e;
      if (!reset) begin
         if (req0_valid && req0_ready)
            exp0.push_back(model(req0_x, req0_y, req0_z, req0_ctl));
         if (req1_valid && req1_ready)
            exp1.push_back(model(req1_x, req1_y, req1_z, req1_ctl));
         vectors++;
         if (req0_ready && req1_ready) begin
            miscompares++;
            $display("FAIL one_grant got both ready want at most one");
         end
         if (rsp0_valid && rsp0_ready) begin
            vectors++;
            if (exp0.size() == 0) begin
               miscompares++;
               $display("FAIL rsp0_unexpected got %h want none", rsp0_result);
            end else begin
               e = exp0.pop_front();
               if ({rsp0_flags, rsp0_result} !== e) begin
                  miscompares++;
                  $display("FAIL rsp0_data got %h want %h",
                           {rsp0_flags, rsp0_result}, e);
               end
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            vectors++;
            if (exp1.size() == 0) begin
               miscompares++;
               $display("FAIL rsp1_unexpected got %h want none", rsp1_result);
            end else begin
               e = exp1.pop_front();
               if ({rsp1_flags, rsp1_result} !== e) begin
                  miscompares++;
                  $display("FAIL rsp1_data got %h want %h",
                           {rsp1_flags, rsp1_result}, e);
               end
            end
         end
      end
   end

   task automatic set_req(input int n, input int idx, input logic v);
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic [5:0]  c;
      x = r2h(real'(idx + 1));
      y = r2h(real'(n + 2));
      z = r2h(real'(idx));
      c = {1'b1, 1'b1, idx[0], 1'b0, idx[1:0]};
      if (n == 0) begin
         req0_x = x; req0_y = y; req0_z = z; req0_ctl = c; req0_valid = v;
      end else begin
         req1_x = x; req1_y = y; req1_z = z; req1_ctl = c; req1_valid = v;
      end
   endtask

   // Called at a negedge: move to the next cycle, new data after a handshake.
   task automatic advance();
      logic g0;
      logic g1;
      g0 = req0_valid && req0_ready;
      g1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (g0) begin i0++; set_req(0, i0, 1'b1); end
      if (g1) begin i1++; set_req(1, i1, 1'b1); end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      exp0.delete();
      exp1.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      repeat (LAT + DEPTH + 4) @(posedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready, dp_issue} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_ready_issue got %b want 000",
                  {req0_ready, req1_ready, dp_issue});
      end
      vectors++;
      if ({dp_x, dp_y, dp_z, dp_ctl} !== 54'h0) begin
         miscompares++;
         $display("FAIL reset_dp_fields got %h want 0",
                  {dp_x, dp_y, dp_z, dp_ctl});
      end
      vectors++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_rsp_valid got %b want 00",
                  {rsp0_valid, rsp1_valid});
      end
      vectors++;
      if ({rsp0_result, rsp0_flags, rsp1_result, rsp1_flags} !== 40'h0) begin
         miscompares++;
         $display("FAIL reset_rsp_data got %h want 0",
                  {rsp0_result, rsp0_flags, rsp1_result, rsp1_flags});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      req0_x = 16'h3C00;
      req0_y = 16'h4000;
      req0_z = 16'h3C00;
      req0_ctl = 6'b110000;
      req0_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready, dp_issue} !== 3'b101) begin
         miscompares++;
         $display("FAIL single_grant got %b want 101",
                  {req0_ready, req1_ready, dp_issue});
      end
      vectors++;
      if ({dp_x, dp_y, dp_z, dp_ctl} !== {48'h3C00_4000_3C00, 6'b110000}) begin
         miscompares++;
         $display("FAIL single_dp_fields got %h want 3c0040003c00/30",
                  {dp_x, dp_y, dp_z, dp_ctl});
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         @(negedge clk);
         vectors++;
         if ({rsp0_valid, rsp1_valid} !== {1'(k == LAT + 1), 1'b0}) begin
            miscompares++;
            $display("FAIL single_latency cycle T+%0d got %b want %b", k,
                     {rsp0_valid, rsp1_valid}, {1'(k == LAT + 1), 1'b0});
         end
         if (k == LAT + 1) begin
            vectors++;
            if ({rsp0_flags, rsp0_result} !== 20'h0_4200) begin
               miscompares++;
               $display("FAIL single_result got %h want 04200",
                        {rsp0_flags, rsp0_result});
            end
         end
      end
   endtask

   task automatic test_contention();
      do_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      i0 = 0;
      i1 = 0;
      set_req(0, i0, 1'b1);
      set_req(1, i1, 1'b1);
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         vectors++;
         if ({dp_issue, req0_ready, req1_ready} !==
             {1'b1, 1'(n % 2 == 0), 1'(n % 2 == 1)}) begin
            miscompares++;
            $display("FAIL contention_grant slot %0d got %b want %b", n,
                     {dp_issue, req0_ready, req1_ready},
                     {1'b1, 1'(n % 2 == 0), 1'(n % 2 == 1)});
         end
         advance();
      end
      drain();
      @(negedge clk);
      vectors++;
      if (exp0.size() + exp1.size() != 0 || i0 != 8 || i1 != 8) begin
         miscompares++;
         $display("FAIL contention_drain got %0d/%0d left %0d/%0d issued want 0/0 8/8",
                  exp0.size(), exp1.size(), i0, i1);
      end
   endtask

   task automatic test_backpressure();
      int cnt;
      int n0;
      do_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b0;
      i1 = 20;
      set_req(1, i1, 1'b1);
      cnt = 0;
      for (int c = 0; c < 2 * DEPTH; c++) begin
         @(negedge clk);
         cnt += int'(req1_ready);
         advance();
      end
      vectors++;
      if (cnt != DEPTH) begin
         miscompares++;
         $display("FAIL bp_grant_count got %0d want %0d", cnt, DEPTH);
      end
      i0 = 0;
      set_req(0, i0, 1'b1);
      n0 = (DEPTH < LAT + 1) ? DEPTH : LAT + 1;
      for (int c = 0; c < n0; c++) begin
         @(negedge clk);
         vectors++;
         if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_req0_only cycle %0d got %b want 10", c,
                     {req0_ready, req1_ready});
         end
         advance();
      end
      req0_valid = 1'b0;
      rsp1_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({rsp1_valid, req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL bp_pop_cycle got %b want 10", {rsp1_valid, req1_ready});
      end
      @(posedge clk);
      #1;
      rsp1_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (req1_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_regrant got %b want 1", req1_ready);
      end
      advance();
      @(negedge clk);
      vectors++;
      if (req1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_single_regrant got %b want 0", req1_ready);
      end
      @(posedge clk);
      #1;
      drain();
      @(negedge clk);
      vectors++;
      if (exp0.size() + exp1.size() != 0) begin
         miscompares++;
         $display("FAIL bp_drain got %0d/%0d left want 0/0",
                  exp0.size(), exp1.size());
      end
   endtask

   task automatic test_full_boundary();
      do_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b0;
      i1 = 8;
      set_req(1, i1, 1'b1);
      for (int c = 0; c < DEPTH; c++) begin
         @(negedge clk);
         vectors++;
         if (req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_fill cycle %0d got %b want 1", c, req1_ready);
         end
         advance();
      end
      repeat (LAT - 1) begin
         @(negedge clk);
         vectors++;
         if (req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_blocked got %b want 0", req1_ready);
         end
         @(posedge clk);
         #1;
      end
      rsp1_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({rsp1_valid, req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL full_push_pop got %b want 10", {rsp1_valid, req1_ready});
      end
      @(posedge clk);
      #1;
      rsp1_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if ({rsp1_valid, req1_ready} !== 2'b11) begin
         miscompares++;
         $display("FAIL full_after_pop got %b want 11", {rsp1_valid, req1_ready});
      end
      @(posedge clk);
      #1;
      drain();
      @(negedge clk);
      vectors++;
      if (exp1.size() != 0 || rsp1_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL full_drain got %0d left valid %b want 0 0",
                  exp1.size(), rsp1_valid);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      set_req(1, 3, 1'b1);
      @(negedge clk);
      vectors++;
      if (req1_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_issue1 got %b want 1", req1_ready);
      end
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      set_req(0, 4, 1'b1);
      @(negedge clk);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      reset = 1'b1;
      exp0.delete();
      exp1.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         vectors++;
         if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_discard cycle %0d got %b want 00", k,
                     {rsp0_valid, rsp1_valid});
         end
      end
      @(posedge clk);
      #1;
      i0 = 10;
      i1 = 11;
      set_req(0, i0, 1'b1);
      set_req(1, i1, 1'b1);
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL mid_ptr_reset got %b want 10", {req0_ready, req1_ready});
      end
      advance();
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL mid_ptr_next got %b want 01", {req0_ready, req1_ready});
      end
      advance();
      drain();
      @(negedge clk);
      vectors++;
      if (exp0.size() + exp1.size() != 0) begin
         miscompares++;
         $display("FAIL mid_drain got %0d/%0d left want 0/0",
                  exp0.size(), exp1.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_full_boundary();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fma16_sched.md
Name: fma16_sched

Overview:
- Schedules and shares one fixed-latency fma16 datapath (multiply/add, normalise, result-assembly stages) between two requesters.
- Arbitrates issue round-robin and tracks each in-flight operation's owner through the pipeline.
- Buffers results in per-requester response FIFOs, with credit-based admission, because the datapath cannot stall.
- Sits between the requesters (or the FP issue logic) and the fma16 datapath.

Parameters:
- LAT, 3: datapath latency in cycles from dp_issue to dp_result valid; legal range 1..8.
- DEPTH, 4: per-requester response FIFO depth and credit limit; power of two, 2..16.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- reqN_valid  in  1  request valid, N=0,1
- reqN_ready  out  1  request accepted this cycle
- reqN_x, reqN_y, reqN_z  in  16 each  fp16 operands
- reqN_ctl  in  6  {mul, add, negp, negz, roundmode[1:0]}
- dp_issue  out  1  operation launched into datapath this cycle
- dp_x, dp_y, dp_z  out  16 each  operands to datapath
- dp_ctl  out  6  control to datapath
- dp_result  in  16  datapath result, valid exactly LAT cycles after issue
- dp_flags  in  4  {nv, of, uf, nx}, aligned with dp_result
- rspN_valid  out  1  response valid, N=0,1
- rspN_ready  in  1  response consumed
- rspN_result  out  16  result
- rspN_flags  out  4  flags

Behaviour:
- Reset is synchronous and active-high; all state is cleared on a clk edge with reset=1.
  - Outputs after reset: all reqN_ready=0, dp_issue=0, dp_x/dp_y/dp_z/dp_ctl=0, rspN_valid=0, rspN_result=0, rspN_flags=0.
  - Reset clears the round-robin pointer to requester 0, both credit counters, the tag pipeline and both FIFOs.
- Reset mid-operation: in-flight operations are discarded. Their dp_result values arriving after reset are ignored and never appear on rspN.
- Eligibility: eligN = reqN_valid & (creditN < DEPTH).
  - creditN counts requester N's operations that are in flight plus those buffered in its FIFO.
- Arbitration (combinational, same cycle):
  - If only one requester is eligible, it is granted.
  - If both are eligible, the pointer's requester is granted.
  - After any grant, the pointer moves to the other requester.
  - With no grant, the pointer holds.
- reqN_ready = grantN. Ready may depend on valid. Requesters hold valid and data stable until ready. At most one grant per cycle.
- dp_issue = grant0 | grant1.
  - dp_x/dp_y/dp_z/dp_ctl carry the winner's fields when issuing.
  - They are all zero when not issuing.
- Tag pipeline:
  - A LAT-deep shift register of {valid, owner} advances every cycle; stage 0 is loaded with {dp_issue, grant1}.
  - When the final stage is valid, dp_result/dp_flags are pushed into that owner's FIFO in the same cycle.
- Response FIFO:
  - Registered output, no bypass. The first response appears LAT+1 cycles after its request handshake, which is the minimum latency.
  - rspN_valid = FIFO non-empty; rspN_result/rspN_flags show the FIFO head.
  - Pop occurs on rspN_valid & rspN_ready. Push and pop in the same cycle are allowed, including when the FIFO is full.
  - Results leave in per-requester issue order.
- Credits:
  - creditN increments on grantN and decrements on rspN pop; both in the same cycle leave it unchanged.
  - creditN ≤ DEPTH always, so FIFO overflow is impossible. A push into a full FIFO without a pop is an assertion failure.
  - A pop lowers the credit, so the requester is eligible again from the next cycle.
- Throughput: one issue per cycle sustained while any requester is eligible.
- Idle cycles: when no requester is eligible, dp_issue=0 and the pointer is unchanged.

Test Plan:
- Single request: req0, x=0x3C00, y=0x4000, z=0x3C00, ctl mul=1 add=1 (bench models the datapath, LAT=3), handshake at T → dp_issue at T with those operands; rsp0_valid at T+4 with result 0x4200, flags 0; rsp1_valid stays 0.
- Contention: both valid every cycle, rsp ready=1, 8 ops each → grants alternate 0,1,0,1… starting with 0; dp_issue high 16 consecutive cycles; each requester's results return in its issue order.
- Backpressure: rsp1_ready=0, req1 continuous → exactly DEPTH=4 req1 grants, then req1_ready=0 while req0 is granted every cycle. Raise rsp1_ready for one cycle → one pop, then exactly one new req1 grant.
- Full boundary: credit1=4 with rsp1 pop and a final-stage req1 push in the same cycle → FIFO count unchanged, no assertion, head advances correctly.
- Reset mid-flight: two ops in flight, reset for one cycle → all rspN_valid=0 from the next cycle; the in-flight results never appear; the next simultaneous request pair grants requester 0 first.
- LAT=1 build: single request at T → rsp valid at T+2; back-to-back issue every cycle with no bubbles.
